// File: rtl/memory_responder.sv
// memory_responder: bus-side responder for the processor's text and data
// segments. Each request is latched in IDLE and fault-checked. A request that
// passes the check waits WAIT_STATES cycles in BUSY and then performs one
// little-endian sub-word access. Every request ends with a single-cycle
// MEM_READY in RESP.
module memory_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int WAIT_STATES   = 2,
  parameter logic [ADDRESS_WIDTH-1:0] TEXT_BASE = 32'h0040_0000,
  parameter logic [ADDRESS_WIDTH-1:0] DATA_BASE = 32'h1001_0000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     MEM_REQ,
  input  logic                     MEM_WE,
  input  logic [1:0]               MEM_SIZE,
  input  logic [ADDRESS_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0]    WR_DATA,
  output logic [DATA_WIDTH-1:0]    RAM_OUT,
  output logic                     MEM_READY,
  output logic                     MEM_ERR,
  output logic [1:0]               ERR_CAUSE
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [ADDRESS_WIDTH-1:0] WIN = ADDRESS_WIDTH'(4 * DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic accept, access;

  // Request fields captured on the accept edge
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     we_q;
  logic [1:0]               size_q;
  logic                     seg_q;    // 1 = data segment, 0 = text segment
  logic [1:0]               cause_q;

  logic [ADDRESS_WIDTH-1:0] off_text, off_data, seg_off;
  logic                     in_text, in_data, misaligned;
  logic [1:0]               cause_in;
  logic [IW:0]              widx;
  logic [DATA_WIDTH-1:0]    rd_word;

  // Both segments share one array: the text half comes first, then the data half
  logic [DATA_WIDTH-1:0] mem [0:2*DEPTH_WORDS-1];

  // Merge store data into the addressed byte or halfword lanes of the old word
  function automatic logic [DATA_WIDTH-1:0] store_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] wd,
    input logic [1:0]            size,
    input logic [1:0]            lane
  );
    logic [DATA_WIDTH-1:0] mask, shifted;
    case (size)
      2'b00: begin
        mask    = DATA_WIDTH'(8'hFF) << {lane, 3'b000};
        shifted = DATA_WIDTH'(wd[7:0]) << {lane, 3'b000};
      end
      2'b01: begin
        mask    = DATA_WIDTH'(16'hFFFF) << {lane[1], 4'b0000};
        shifted = DATA_WIDTH'(wd[15:0]) << {lane[1], 4'b0000};
      end
      default: begin
        mask    = '1;
        shifted = wd;
      end
    endcase
    return (old_word & ~mask) | (shifted & mask);
  endfunction

  // Move the addressed lane down to bit 0 and zero-extend it
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            size,
    input logic [1:0]            lane
  );
    logic [DATA_WIDTH-1:0] sb, sh;
    sb = word >> {lane, 3'b000};
    sh = word >> {lane[1], 4'b0000};
    case (size)
      2'b00:   return DATA_WIDTH'(sb[7:0]);
      2'b01:   return DATA_WIDTH'(sh[15:0]);
      default: return word;
    endcase
  endfunction

  // Window decode and fault priority for the request presented in IDLE
  always_comb begin
    off_text   = Addr - TEXT_BASE;
    off_data   = Addr - DATA_BASE;
    in_text    = (Addr >= TEXT_BASE) && (off_text < WIN);
    in_data    = (Addr >= DATA_BASE) && (off_data < WIN);
    misaligned = ((MEM_SIZE == 2'b01) && Addr[0]) ||
                 (MEM_SIZE[1] && (Addr[1:0] != 2'b00));
    if (misaligned)               cause_in = 2'b01;
    else if (!in_text && !in_data) cause_in = 2'b10;
    else if (MEM_WE && in_text)    cause_in = 2'b11;
    else                           cause_in = 2'b00;
  end

  // Word index into the shared array from the latched address
  always_comb begin
    seg_off = addr_q - (seg_q ? DATA_BASE : TEXT_BASE);
    widx    = {seg_q, IW'(seg_off >> 2)};
    rd_word = mem[widx];
  end

  // Next-state logic and bus outputs
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    MEM_READY = 1'b0;
    MEM_ERR   = 1'b0;
    ERR_CAUSE = 2'b00;
    case (state)
      IDLE: begin
        if (MEM_REQ) begin
          accept = 1'b1;
          if (cause_in != 2'b00) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = WS;
          end
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        MEM_READY = 1'b1;
        MEM_ERR   = (cause_q != 2'b00);
        ERR_CAUSE = cause_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, wait counter and fault cause
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      cause_q <= 2'b00;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) cause_q <= cause_in;
    end
  end

  // Request capture; all fields are held so inputs may change after accept
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q  <= Addr;
      wdata_q <= WR_DATA;
      we_q    <= MEM_WE;
      size_q  <= MEM_SIZE;
      seg_q   <= in_data;
    end
  end

  // Store path; a reset on the access edge suppresses the write
  always_ff @(posedge CLK) begin
    if (!RST && access && we_q) begin
      mem[widx] <= store_merge(rd_word, wdata_q, size_q, addr_q[1:0]);
    end
  end

  // Load result register, updated only by successful loads
  always_ff @(posedge CLK) begin
    if (RST) begin
      RAM_OUT <= '0;
    end else if (access && !we_q) begin
      RAM_OUT <= load_extract(rd_word, size_q, addr_q[1:0]);
    end
  end

endmodule
